// File: rtl/apb_requester.sv
// APB4 requester: turns one valid/ready command into a single APB transfer and
// returns the completion on a valid/ready response channel, with a PREADY timeout.
module apb_requester #(
  parameter int REGWIDTH       = 32,
  parameter int G_ADDR_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [G_ADDR_WIDTH-1:0] req_addr,
  input  logic [REGWIDTH-1:0]     req_wdata,
  input  logic [REGWIDTH/8-1:0]   req_strb,
  input  logic [2:0]              req_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [REGWIDTH-1:0]     rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    m_apb_psel,
  output logic                    m_apb_penable,
  output logic                    m_apb_pwrite,
  output logic [2:0]              m_apb_pprot,
  output logic [G_ADDR_WIDTH-1:0] m_apb_paddr,
  output logic [REGWIDTH-1:0]     m_apb_pwdata,
  output logic [REGWIDTH/8-1:0]   m_apb_pstrb,
  input  logic                    m_apb_pready,
  input  logic                    m_apb_pslverr,
  input  logic [REGWIDTH-1:0]     m_apb_prdata
);

  // state  | meaning
  // IDLE   | waiting for a command; req_ready high
  // SETUP  | APB setup phase (psel=1, penable=0), one cycle
  // ACCESS | APB access phase, waiting for pready or the timeout
  // RESP   | response held on rsp_* until rsp_ready

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam int CW         = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int LIMIT      = TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          limit_hit;

  assign req_ready = (state == IDLE) && !rst;
  assign limit_hit = TIMEOUT_EN && (wait_cnt == CW'(LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      m_apb_psel    <= 1'b0;
      m_apb_penable <= 1'b0;
      m_apb_pwrite  <= 1'b0;
      m_apb_pprot   <= '0;
      m_apb_paddr   <= '0;
      m_apb_pwdata  <= '0;
      m_apb_pstrb   <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      rsp_timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            m_apb_psel    <= 1'b1;
            m_apb_penable <= 1'b0;
            m_apb_pwrite  <= req_write;
            m_apb_pprot   <= req_prot;
            m_apb_paddr   <= req_addr;
            m_apb_pwdata  <= req_wdata;
            m_apb_pstrb   <= req_write ? req_strb : '0;
            state         <= SETUP;
          end
        end
        SETUP: begin
          m_apb_penable <= 1'b1;
          wait_cnt      <= '0;
          state         <= ACCESS;
        end
        ACCESS: begin
          // pready has priority over a timeout landing on the same edge
          if (m_apb_pready) begin
            m_apb_psel    <= 1'b0;
            m_apb_penable <= 1'b0;
            m_apb_pstrb   <= '0;
            rsp_valid     <= 1'b1;
            rsp_rdata     <= m_apb_pwrite ? '0 : m_apb_prdata;
            rsp_err       <= m_apb_pslverr;
            rsp_timeout   <= 1'b0;
            state         <= RESP;
          end else if (limit_hit) begin
            m_apb_psel    <= 1'b0;
            m_apb_penable <= 1'b0;
            m_apb_pstrb   <= '0;
            rsp_valid     <= 1'b1;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b1;
            rsp_timeout   <= 1'b1;
            state         <= RESP;
          end else if (TIMEOUT_EN) begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_requester.md
# apb_requester

APB4 requester (initiator) that turns a single-outstanding valid/ready command into one APB transfer and returns the result on a valid/ready response channel. It drives the `m_apb_*` side of the same APB4 bus that register blocks accept on their `s_apb_*` ports, so it is the master end used by CPU-side bridges and by test harnesses. The block adds a per-transfer `PREADY` timeout so a hung completer cannot stall the requester.

## Interface
- `REGWIDTH`, 32: APB data width; a multiple of 8.
- `G_ADDR_WIDTH`, 4: APB address width.
- `TIMEOUT_CYCLES`, 16: maximum number of ACCESS cycles before an abort; 0 disables the timeout.

Clock and reset: one clock; reset is synchronous and active-high.

- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  command valid.
- `req_ready`  out  1  command accepted when high with `req_valid`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  G_ADDR_WIDTH  address.
- `req_wdata`  in  REGWIDTH  write data.
- `req_strb`  in  REGWIDTH/8  write strobes.
- `req_prot`  in  3  PPROT value.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumed when high with `rsp_valid`.
- `rsp_rdata`  out  REGWIDTH  read data; 0 for writes and timeouts.
- `rsp_err`  out  1  PSLVERR or timeout.
- `rsp_timeout`  out  1  transfer aborted by timeout.
- `m_apb_psel`, `m_apb_penable`, `m_apb_pwrite`  out  1 each  APB control.
- `m_apb_pprot`  out  3
- `m_apb_paddr`  out  G_ADDR_WIDTH
- `m_apb_pwdata`  out  REGWIDTH
- `m_apb_pstrb`  out  REGWIDTH/8
- `m_apb_pready`, `m_apb_pslverr`  in  1 each.
- `m_apb_prdata`  in  REGWIDTH.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Only one transfer is outstanding at a time.
- IDLE:
  - `req_ready = 1` (forced 0 while `rst` is high).
  - On `req_valid & req_ready`, capture write, addr, wdata, strb and prot, then go to SETUP.
- SETUP (exactly 1 cycle):
  - `psel = 1`, `penable = 0`.
  - Address, control and data are driven from the captured registers.
  - `pstrb` is forced to 0 for reads.
  - Next state is ACCESS.
- ACCESS:
  - `psel = 1`, `penable = 1`.
  - All APB outputs stay stable until `pready` is sampled high.
  - On `pready`:
    - `rsp_rdata` is set to `prdata` for reads and to 0 for writes.
    - `rsp_err` is set to `pslverr` and `rsp_timeout` to 0.
    - Next state is RESP.
- Timeout:
  - The wait counter clears on entry to ACCESS and increments on each ACCESS cycle with `pready` low.
  - The counter is `$clog2(TIMEOUT_CYCLES+1)` bits wide.
  - On an ACCESS edge where the counter equals `TIMEOUT_CYCLES-1` and `pready` is low:
    - The transfer aborts.
    - `rsp_err = 1`, `rsp_timeout = 1`, `rsp_rdata = 0`.
    - Next state is RESP.
  - If `pready` and the limit coincide, `pready` wins.
- RESP:
  - `psel = 0`, `penable = 0`, `rsp_valid = 1`.
  - The response fields are held until `rsp_ready`.
  - On the handshake, go to IDLE.
- Idle APB outputs: `psel`, `penable` and `pstrb` are 0. `paddr`, `pwdata`, `pwrite` and `pprot` hold their last values.
- Reset, including mid-transfer:
  - State goes to IDLE and the counter to 0.
  - All outputs read 0 from the cycle after the reset edge.
  - An aborted transfer produces no response.

## Timing
- Accept edge t0 → SETUP in cycle t0+1 → ACCESS from t0+2.
- Zero wait states: `pready` sampled at the end of t0+2 gives `rsp_valid` high in t0+3.
- N wait states add N cycles.
- With `rsp_ready` tied high, RESP lasts 1 cycle and IDLE is re-entered at t0+4. Maximum throughput is therefore one transfer per 4 cycles.
- Timeout path: at most `TIMEOUT_CYCLES` ACCESS cycles, then RESP on the next cycle.
- `rsp_*` outputs are registered; `req_ready` is decoded from state.
- After `rst` deasserts, `req_ready` is 1 in the first following cycle.

## Test plan
- **Zero-wait write:** write 0xDEADBEEF to 0x4 with strb 0xF and `pready` tied high.
  - Cycle t0+1: `psel = 1`, `penable = 0`.
  - Cycle t0+2: `penable = 1`.
  - Cycle t0+3: `rsp_valid = 1`, `rsp_err = 0`, `rsp_rdata = 0`.
- **Read with wait states:** read 0x8 with `pready` low for 3 cycles, then `prdata = 0x12345678`.
  - `rsp_valid` rises at t0+6 with `rsp_rdata = 0x12345678`.
  - `pstrb` is 0 throughout.
- **Error completion:** a write completes with `pslverr = 1`.
  - Response: `rsp_err = 1`, `rsp_timeout = 0`.
- **Timeout:** `TIMEOUT_CYCLES = 4`, `pready` held low.
  - Exactly 4 ACCESS cycles, then `psel = 0`.
  - Response: `rsp_err = 1`, `rsp_timeout = 1`, `rsp_rdata = 0`.
  - `pready` rising on the 4th ACCESS cycle yields a normal completion instead.
- **Response backpressure and back-to-back:** `rsp_ready = 0` for 5 cycles, with a second request pending.
  - `rsp_valid` and the response data stay stable.
  - `req_ready` stays 0.
  - The second transfer's SETUP starts 2 cycles after the response handshake.
- **Reset mid-transfer:** `rst` pulsed during ACCESS.
  - All outputs are 0 on the next cycle and no response is produced.
  - A new request afterwards completes normally.
